// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: captures A, B and Bin, then resolves one bit per cycle LSB first.
// Optional macro SERIAL_SUB_OVF_EN adds a registered two's-complement overflow output ovf.
module serial_subtractor #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   a_sr, a_sr_nx;
  logic [WIDTH-1:0]   b_sr, b_sr_nx;
  logic [WIDTH-1:0]   d_sr, d_sr_nx;
  logic               br, br_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [WIDTH-1:0]   diff_nx;
  logic               bout_nx;
  logic               bit_d;
  logic               bit_br;
`ifdef SERIAL_SUB_OVF_EN
  logic               ovf_nx;
`endif

  // Full-subtractor slice on the current LSBs of the operand shift registers.
  always_comb begin
    bit_d  = a_sr[0] ^ b_sr[0] ^ br;
    bit_br = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & br) | (b_sr[0] & br);
  end

  // Next-state and datapath update.
  always_comb begin
    state_nx = state;
    a_sr_nx  = a_sr;
    b_sr_nx  = b_sr;
    d_sr_nx  = d_sr;
    br_nx    = br;
    cnt_nx   = cnt;
    diff_nx  = Diff;
    bout_nx  = Bout;
`ifdef SERIAL_SUB_OVF_EN
    ovf_nx   = ovf;
`endif
    unique case (state)
      IDLE: begin
        if (start_valid) begin
          a_sr_nx  = A;
          b_sr_nx  = B;
          br_nx    = Bin;
          d_sr_nx  = '0;
          cnt_nx   = '0;
          state_nx = RUN;
        end
      end
      RUN: begin
        a_sr_nx = a_sr >> 1;
        b_sr_nx = b_sr >> 1;
        // Result bits enter at the MSB so the LSB-first stream lands in place.
        d_sr_nx = (d_sr >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));
        br_nx   = bit_br;
        cnt_nx  = cnt + CNT_W'(1);
        if (cnt == LAST_BIT) begin
          diff_nx  = d_sr_nx;
          bout_nx  = bit_br;
`ifdef SERIAL_SUB_OVF_EN
          ovf_nx   = br ^ bit_br;
`endif
          state_nx = DONE;
        end
      end
      DONE: begin
        if (done_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, datapath and handshake flags; flags track the next state so they stay registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a_sr        <= '0;
      b_sr        <= '0;
      d_sr        <= '0;
      br          <= 1'b0;
      cnt         <= '0;
      Diff        <= '0;
      Bout        <= 1'b0;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      done_valid  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf         <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      a_sr        <= a_sr_nx;
      b_sr        <= b_sr_nx;
      d_sr        <= d_sr_nx;
      br          <= br_nx;
      cnt         <= cnt_nx;
      Diff        <= diff_nx;
      Bout        <= bout_nx;
      start_ready <= (state_nx == IDLE);
      busy        <= (state_nx == RUN);
      done_valid  <= (state_nx == DONE);
`ifdef SERIAL_SUB_OVF_EN
      ovf         <= ovf_nx;
`endif
    end
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the operand and result width in bits (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, an asynchronous active-high reset.
REQ-004 The block SHALL have port start_valid, input, 1, indicating the operand request is valid.
REQ-005 The block SHALL have port start_ready, output, 1, indicating the block can accept a request.
REQ-006 The block SHALL have port A, input, WIDTH, the minuend.
REQ-007 The block SHALL have port B, input, WIDTH, the subtrahend.
REQ-008 The block SHALL have port Bin, input, 1, the borrow-in.
REQ-009 The block SHALL have port Diff, output, WIDTH, the registered difference.
REQ-010 The block SHALL have port Bout, output, 1, the registered borrow-out.
REQ-011 The block SHALL have port done_valid, output, 1, indicating the result is valid.
REQ-012 The block SHALL have port done_ready, input, 1, indicating the consumer accepts the result.
REQ-013 The block SHALL have port busy, output, 1, which is high while a subtraction is in progress.

Function
REQ-014 The block SHALL implement states IDLE, RUN and DONE, with start_ready = (state==IDLE), busy = (state==RUN) and done_valid = (state==DONE).
REQ-015 When start_valid and start_ready are both high in IDLE, the block SHALL capture A, B and Bin into internal shift registers, clear the bit counter, and enter RUN.
REQ-016 In RUN, the block SHALL process one bit per cycle, LSB first, as d = a^b^br, with next borrow br' = (~a&b) | (~a&br) | (b&br), where br is initialised to the captured Bin.
REQ-017 After exactly WIDTH RUN cycles, the block SHALL load Diff and Bout and enter DONE, so done_valid rises WIDTH cycles after the accepting edge.
REQ-018 The result SHALL satisfy Diff = (A - B - Bin) mod 2^WIDTH, and Bout = 1 iff A < B + Bin (unsigned comparison).
REQ-019 In DONE, Diff and Bout SHALL hold stable until done_valid and done_ready are both high, after which the block SHALL return to IDLE on that edge.
REQ-020 Diff and Bout SHALL retain their last result in IDLE and RUN, and SHALL change only on DONE entry.
REQ-021 start_valid SHALL be ignored in RUN and DONE, and changes on A, B or Bin after capture SHALL have no effect.
REQ-022 done_ready SHALL be ignored outside DONE.
REQ-023 A new request SHALL be accepted no earlier than the cycle after the DONE handshake, giving a minimum spacing of WIDTH+2 cycles.
REQ-024 For WIDTH=1, the block SHALL spend exactly one cycle in RUN.

Reset
REQ-025 While rst is high, the block SHALL immediately force state IDLE, Diff=0, Bout=0, the counter and shift registers to 0, done_valid=0, busy=0 and start_ready=1.
REQ-026 An assertion of rst during RUN or DONE SHALL abort the operation with no done_valid pulse; the first acceptance after release SHALL start a fresh operation.

Configuration
REQ-027 When macro SERIAL_SUB_OVF_EN is defined, the block SHALL add output ovf, 1 bit, registered with Diff, equal to the borrow into the MSB XOR the borrow out of the MSB (two's-complement overflow); ovf SHALL reset to 0.
REQ-028 When SERIAL_SUB_OVF_EN is undefined, port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 With WIDTH=3, A=5, B=3, Bin=0 -> Diff=2 and Bout=0, with done_valid high exactly 3 cycles after acceptance and busy high for those 3 cycles.
REQ-030 With A=2, B=5, Bin=0 -> Diff=5 and Bout=1; with A=0, B=0, Bin=1 -> Diff=7 and Bout=1.
REQ-031 Holding done_ready low for 4 cycles with start_valid high throughout -> Diff/Bout stable, start_ready=0, no new capture; a single handshake then returns the block to IDLE.
REQ-032 Asserting rst for 1 cycle mid-RUN -> all outputs 0 and start_ready=1 at once, with no done_valid; a following request with A=7, B=1 -> Diff=6.
REQ-033 With SERIAL_SUB_OVF_EN defined, A=3, B=7, Bin=0 -> Diff=4, Bout=1, ovf=1; A=1, B=1 -> Diff=0, ovf=0.
